img_pingpong_buf: RTL and testbench

IMG_PINGPONG_BUF -- requirements
Module: img_pingpong_buf

---
 rtl/img_buf_pkg.sv | 22 ++
 rtl/img_bank_ram.sv | 45 ++++
 rtl/img_pingpong_buf.sv | 237 +++++++++++++++++++++++
 tb/tb_img_pingpong_buf.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_buf_pkg.sv
// Shared definitions for the ping-pong image frame buffer.
// Contents: parameter defaults (depth, lanes, pixel width, address width),
// the per-bank ownership state enum and the default pixel-word type.
package img_buf_pkg;

    localparam int unsigned DEF_DEPTH = 49;  // 784 pixels / 16 lanes
    localparam int unsigned DEF_LANES = 16;
    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned DEF_AW    = 7;

    // Ownership lifecycle of one bank.
    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } bank_state_t;

    // One pixel word at the default geometry: LANES pixels of DW bits.
    typedef logic [DEF_LANES-1:0][DEF_DW-1:0] pix_word_t;

endpackage

// File: rtl/img_bank_ram.sv
// Single frame bank: DEPTH words of LANES x DW pixels.
// Ports:
//   clk, rst_n       - clock, synchronous active-low reset (read register only)
//   we, wr_addr,     - write port, stores wr_data on the rising edge
//   wr_data
//   re, rd_addr      - read port; rd_data loads on the edge when re=1 and
//   rd_data            holds otherwise
// Memory contents are never reset.
module img_bank_ram
    import img_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [IW-1:0]             wr_addr,
    input  logic [LANES-1:0][DW-1:0]  wr_data,
    input  logic                      re,
    input  logic [IW-1:0]             rd_addr,
    output logic [LANES-1:0][DW-1:0]  rd_data
);

    logic [LANES-1:0][DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its last word when not enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/img_pingpong_buf.sv
// Ping-pong frame buffer between the image-processing writer and the NN reader.
// Two banks alternate: the writer fills one while the reader owns the other.
// A frame completed while no bank is free puts the write side into DROP,
// discarding the next frame and pulsing oOvf on its end-of-frame.
// Ports:
//   clk, rst_n                    - clock, synchronous active-low reset
//   iDmem_wren/addr/data          - pixel word writes from the image FSM
//   iFrame_done                   - end-of-frame pulse
//   iRd_req/iRd_addr              - reader requests, one-cycle latency
//   oRd_data/oRd_valid            - read word and its valid flag
//   oFrame_rdy                    - reader owns a complete frame
//   iFrame_release                - reader finished with the frame
//   oOvf                          - frame dropped pulse
//   oAddr_err                     - out-of-range write pulse
//   oChksum                       - (IMG_BUF_CHKSUM_EN only) lane sum of the
//                                   frame being read
// Optional feature macro: IMG_BUF_CHKSUM_EN.
module img_pingpong_buf
    import img_buf_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iDmem_wren,
    input  logic [AW-1:0] iDmem_addr,
    input  logic [DW-1:0] iDmem_data [LANES],
    input  logic          iFrame_done,
    input  logic          iRd_req,
    input  logic [AW-1:0] iRd_addr,
    output logic [DW-1:0] oRd_data [LANES],
    output logic          oRd_valid,
    output logic          oFrame_rdy,
    input  logic          iFrame_release,
`ifdef IMG_BUF_CHKSUM_EN
    output logic [DW-1:0] oChksum,
`endif
    output logic          oOvf,
    output logic          oAddr_err
);

    localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1 = AW + 1;
    localparam logic [AW:0] DEPTH_W = AW1'(DEPTH);

    typedef logic [LANES-1:0][DW-1:0] word_t;

    bank_state_t bs_q [2];
    bank_state_t bs_d [2];
    logic wr_bank_q, wr_bank_d;
    logic rd_bank_q, rd_bank_d;
    logic drop_q, drop_d;
    logic rdy_q, rdy_d;
    logic ovf_q, ovf_d;
    logic aerr_q, aerr_d;
    logic rvalid_q, rvalid_d;
    logic rsel_q, rsel_d;

    logic wr_addr_ok_c, rd_addr_ok_c;
    logic wr_acc_c, rd_acc_c, rel_acc_c, grant_c;
    logic [1:0] ram_we_c, ram_re_c;
    word_t wr_word_c;
    word_t ram_rd [2];

    // Request qualification.
    assign wr_addr_ok_c = ({1'b0, iDmem_addr} < DEPTH_W);
    assign rd_addr_ok_c = ({1'b0, iRd_addr} < DEPTH_W);
    assign wr_acc_c  = iDmem_wren && wr_addr_ok_c && !drop_q &&
                       ((bs_q[wr_bank_q] == FREE) || (bs_q[wr_bank_q] == FILLING));
    assign rd_acc_c  = iRd_req && rdy_q && rd_addr_ok_c;
    assign rel_acc_c = iFrame_release && rdy_q;
    // Hand the next frame to the reader once nothing is being read.
    assign grant_c   = (bs_q[rd_bank_q] == READY) &&
                       (bs_q[0] != READING) && (bs_q[1] != READING);

    assign ram_we_c = {wr_acc_c && rst_n &&  wr_bank_q,
                       wr_acc_c && rst_n && !wr_bank_q};
    assign ram_re_c = {rd_acc_c &&  rd_bank_q,
                       rd_acc_c && !rd_bank_q};

    // Unpacked pixel port to packed RAM word.
    always_comb begin
        wr_word_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            wr_word_c[l] = iDmem_data[l];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        img_bank_ram #(
            .DEPTH (DEPTH),
            .LANES (LANES),
            .DW    (DW),
            .IW    (IW)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (ram_we_c[b]),
            .wr_addr (iDmem_addr[IW-1:0]),
            .wr_data (wr_word_c),
            .re      (ram_re_c[b]),
            .rd_addr (iRd_addr[IW-1:0]),
            .rd_data (ram_rd[b])
        );
    end

    // Bank ownership next state. Release is applied before end-of-frame so a
    // bank freed this cycle is available to the closing frame.
    always_comb begin
        bs_d      = bs_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        drop_d    = drop_q;
        rdy_d     = rdy_q;
        ovf_d     = 1'b0;
        aerr_d    = iDmem_wren && !wr_addr_ok_c;
        rvalid_d  = rd_acc_c;
        rsel_d    = rd_acc_c ? rd_bank_q : rsel_q;

        if (grant_c) begin
            bs_d[rd_bank_q] = READING;
            rdy_d           = 1'b1;
        end

        if (rel_acc_c) begin
            bs_d[rd_bank_q] = FREE;
            rd_bank_d       = ~rd_bank_q;
            rdy_d           = 1'b0;
        end

        if (wr_acc_c && (bs_q[wr_bank_q] == FREE)) begin
            bs_d[wr_bank_q] = FILLING;
        end

        if (drop_q) begin
            if (iFrame_done) begin
                ovf_d = 1'b1;
            end
            // Leave DROP as soon as the other bank has been freed.
            if (bs_q[~wr_bank_q] == FREE) begin
                drop_d    = 1'b0;
                wr_bank_d = ~wr_bank_q;
            end
        end else if (iFrame_done) begin
            bs_d[wr_bank_q] = READY;
            if (bs_d[~wr_bank_q] == FREE) begin
                wr_bank_d = ~wr_bank_q;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bs_q[0]   <= FREE;
            bs_q[1]   <= FREE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            drop_q    <= 1'b0;
            rdy_q     <= 1'b0;
            ovf_q     <= 1'b0;
            aerr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rsel_q    <= 1'b0;
        end else begin
            bs_q      <= bs_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            drop_q    <= drop_d;
            rdy_q     <= rdy_d;
            ovf_q     <= ovf_d;
            aerr_q    <= aerr_d;
            rvalid_q  <= rvalid_d;
            rsel_q    <= rsel_d;
        end
    end

    // Read data comes from the bank that served the last accepted read.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            oRd_data[l] = ram_rd[rsel_q][l];
        end
    end

    assign oRd_valid  = rvalid_q;
    assign oFrame_rdy = rdy_q;
    assign oOvf       = ovf_q;
    assign oAddr_err  = aerr_q;

`ifdef IMG_BUF_CHKSUM_EN
    // Per-bank running lane sum; latched for the reader when a frame is granted.
    logic [DW-1:0] sum_q [2];
    logic [DW-1:0] sum_d [2];
    logic [DW-1:0] chk_q, chk_d;
    logic [DW-1:0] lane_sum_c;

    always_comb begin
        lane_sum_c = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_sum_c = lane_sum_c + iDmem_data[l];
        end
    end

    always_comb begin
        sum_d = sum_q;
        chk_d = chk_q;
        if (wr_acc_c) begin
            sum_d[wr_bank_q] = ((bs_q[wr_bank_q] == FREE) ? '0 : sum_q[wr_bank_q]) + lane_sum_c;
        end else if (iFrame_done && !drop_q && (bs_q[wr_bank_q] == FREE)) begin
            // Empty frame: never entered FILLING, so clear here instead.
            sum_d[wr_bank_q] = '0;
        end
        if (grant_c) begin
            chk_d = sum_q[rd_bank_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q[0] <= '0;
            sum_q[1] <= '0;
            chk_q    <= '0;
        end else begin
            sum_q <= sum_d;
            chk_q <= chk_d;
        end
    end

    assign oChksum = chk_q;
`endif

endmodule

// File: tb/tb_img_pingpong_buf.sv
// Self-checking bench for img_pingpong_buf: per-scenario tasks with a read
// scoreboard (expected words queued at request, popped when oRd_valid rises).
module tb_img_pingpong_buf;

    localparam int unsigned DEPTH = 49;
    localparam int unsigned LANES = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 7;

    typedef logic [LANES*DW-1:0] flat_t;

    logic          clk;
    logic          rst_n;
    logic          iDmem_wren;
    logic [AW-1:0] iDmem_addr;
    logic [DW-1:0] iDmem_data [LANES];
    logic          iFrame_done;
    logic          iRd_req;
    logic [AW-1:0] iRd_addr;
    logic [DW-1:0] oRd_data [LANES];
    logic          oRd_valid;
    logic          oFrame_rdy;
    logic          iFrame_release;
    logic          oOvf;
    logic          oAddr_err;
`ifdef IMG_BUF_CHKSUM_EN
    logic [DW-1:0] oChksum;
`endif

    int n_vec = 0;
    int n_err = 0;
    int ovf_cnt = 0;
    int aerr_cnt = 0;
    flat_t exp_q [$];

    img_pingpong_buf #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .DW    (DW),
        .AW    (AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iDmem_wren     (iDmem_wren),
        .iDmem_addr     (iDmem_addr),
        .iDmem_data     (iDmem_data),
        .iFrame_done    (iFrame_done),
        .iRd_req        (iRd_req),
        .iRd_addr       (iRd_addr),
        .oRd_data       (oRd_data),
        .oRd_valid      (oRd_valid),
        .oFrame_rdy     (oFrame_rdy),
        .iFrame_release (iFrame_release),
`ifdef IMG_BUF_CHKSUM_EN
        .oChksum        (oChksum),
`endif
        .oOvf           (oOvf),
        .oAddr_err      (oAddr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input int unsigned off, input int unsigned a,
                                          input int unsigned l);
        return DW'(off + a * 16 + l);
    endfunction

    function automatic flat_t word_of(input int unsigned off, input int unsigned a);
        flat_t w;
        for (int unsigned l = 0; l < LANES; l++) w[l*DW +: DW] = pix(off, a, l);
        return w;
    endfunction

    function automatic flat_t flat_rd();
        flat_t w;
        for (int unsigned l = 0; l < LANES; l++) w[l*DW +: DW] = oRd_data[l];
        return w;
    endfunction

    // Scoreboard consumer and pulse counters, sampled 1 time unit after the edge.
    always @(posedge clk) begin : mon
        flat_t e;
        #1;
        if (oRd_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected got=%h", flat_rd());
            end else begin
                e = exp_q.pop_front();
                if (flat_rd() !== e) begin
                    n_err++;
                    $display("FAIL rd_data got=%h exp=%h", flat_rd(), e);
                end
            end
        end
        if (oOvf === 1'b1) ovf_cnt++;
        if (oAddr_err === 1'b1) aerr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        iDmem_wren = 1'b0;
        iDmem_addr = '0;
        for (int unsigned l = 0; l < LANES; l++) iDmem_data[l] = '0;
        iFrame_done = 1'b0;
        iRd_req = 1'b0;
        iRd_addr = '0;
        iFrame_release = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic fill_n(input int unsigned off, input int unsigned n, input bit done_last);
        for (int unsigned a = 0; a < n; a++) begin
            iDmem_wren = 1'b1;
            iDmem_addr = AW'(a);
            for (int unsigned l = 0; l < LANES; l++) iDmem_data[l] = pix(off, a, l);
            iFrame_done = done_last && (a == n - 1);
            tick();
        end
        iDmem_wren = 1'b0;
        iFrame_done = 1'b0;
    endtask

    task automatic wr_junk(input int unsigned addr);
        iDmem_wren = 1'b1;
        iDmem_addr = AW'(addr);
        for (int unsigned l = 0; l < LANES; l++) iDmem_data[l] = 16'hFFFF;
        tick();
        iDmem_wren = 1'b0;
    endtask

    task automatic rd(input int unsigned addr, input int unsigned off, input bit expect_ok);
        iRd_req = 1'b1;
        iRd_addr = AW'(addr);
        if (expect_ok) exp_q.push_back(word_of(off, addr));
        tick();
        iRd_req = 1'b0;
    endtask

    task automatic pulse_done();
        iFrame_done = 1'b1;
        tick();
        iFrame_done = 1'b0;
    endtask

    task automatic pulse_release();
        iFrame_release = 1'b1;
        tick();
        iFrame_release = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b exp=0", oFrame_rdy); end
        n_vec++; if (oRd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", oRd_valid); end
        n_vec++; if (oOvf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", oOvf); end
        n_vec++; if (oAddr_err !== 1'b0) begin n_err++; $display("FAIL reset_aerr got=%b exp=0", oAddr_err); end
        n_vec++; if (flat_rd() !== '0) begin n_err++; $display("FAIL reset_data got=%h exp=0", flat_rd()); end
`ifdef IMG_BUF_CHKSUM_EN
        n_vec++; if (oChksum !== '0) begin n_err++; $display("FAIL reset_chksum got=%h exp=0", oChksum); end
`endif
        rst_n = 1'b1;
        tick();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL post_reset_rdy got=%b exp=0", oFrame_rdy); end
    endtask

    task automatic test_fill_read();
        do_reset();
        fill_n(0, DEPTH, 1'b0);
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL fr_rdy_before_done got=%b exp=0", oFrame_rdy); end
        pulse_done();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL fr_rdy_1cyc got=%b exp=0", oFrame_rdy); end
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL fr_rdy_2cyc got=%b exp=1", oFrame_rdy); end
        rd(5, 0, 1'b1);
        n_vec++; if (oRd_valid !== 1'b1) begin n_err++; $display("FAIL fr_valid got=%b exp=1", oRd_valid); end
        n_vec++; if (oRd_data[3] !== 16'h0053) begin n_err++; $display("FAIL fr_lane3 got=%h exp=0053", oRd_data[3]); end
        for (int unsigned a = 0; a < DEPTH; a++) rd(a, 0, 1'b1);
        repeat (20) rd($urandom_range(DEPTH - 1, 0), 0, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fr_pending got=%0d exp=0", exp_q.size()); end
        pulse_release();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL fr_release got=%b exp=0", oFrame_rdy); end
        // Release without ownership must not move the read pointer.
        pulse_release();
        fill_n(16'h0A00, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL fr_second_rdy got=%b exp=1", oFrame_rdy); end
        rd(0, 16'h0A00, 1'b1);
        rd(48, 16'h0A00, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL fr_second_pending got=%0d exp=0", exp_q.size()); end
        pulse_release();
    endtask

    task automatic test_overflow();
        int o0;
        do_reset();
        o0 = ovf_cnt;
        fill_n(16'h0000, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ov_a_rdy got=%b exp=1", oFrame_rdy); end
        fill_n(16'h1000, DEPTH, 1'b1);
        tick();
        n_vec++; if (ovf_cnt != o0) begin n_err++; $display("FAIL ov_on_b got=%0d exp=0", ovf_cnt - o0); end
        fill_n(16'h2000, DEPTH, 1'b1);
        tick();
        n_vec++; if (ovf_cnt - o0 != 1) begin n_err++; $display("FAIL ov_on_c got=%0d exp=1", ovf_cnt - o0); end
        rd(7, 16'h0000, 1'b1);
        rd(48, 16'h0000, 1'b1);
        pulse_release();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL ov_rel_a got=%b exp=0", oFrame_rdy); end
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ov_b_rdy got=%b exp=1", oFrame_rdy); end
        for (int unsigned a = 0; a < DEPTH; a++) rd(a, 16'h1000, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ov_pending got=%0d exp=0", exp_q.size()); end
        n_vec++; if (ovf_cnt - o0 != 1) begin n_err++; $display("FAIL ov_total got=%0d exp=1", ovf_cnt - o0); end
        pulse_release();
        // Write side must have rejoined the alternation after DROP.
        fill_n(16'h3000, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ov_d_rdy got=%b exp=1", oFrame_rdy); end
        rd(0, 16'h3000, 1'b1);
        rd(30, 16'h3000, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ov_d_pending got=%0d exp=0", exp_q.size()); end
        pulse_release();
    endtask

    task automatic test_addr_err();
        int a0;
        flat_t hold;
        do_reset();
        a0 = aerr_cnt;
        fill_n(16'h4000, DEPTH, 1'b0);
        wr_junk(49);
        n_vec++; if (oAddr_err !== 1'b1) begin n_err++; $display("FAIL ae_pulse got=%b exp=1", oAddr_err); end
        tick();
        n_vec++; if (oAddr_err !== 1'b0) begin n_err++; $display("FAIL ae_clear got=%b exp=0", oAddr_err); end
        wr_junk(69);
        tick();
        n_vec++; if (aerr_cnt - a0 != 2) begin n_err++; $display("FAIL ae_count got=%0d exp=2", aerr_cnt - a0); end
        hold = flat_rd();
        rd(3, 0, 1'b0);
        n_vec++; if (oRd_valid !== 1'b0) begin n_err++; $display("FAIL ae_rd_notrdy got=%b exp=0", oRd_valid); end
        pulse_done();
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ae_rdy got=%b exp=1", oFrame_rdy); end
        for (int unsigned a = 0; a < DEPTH; a++) rd(a, 16'h4000, 1'b1);
        hold = flat_rd();
        rd(60, 0, 1'b0);
        n_vec++; if (oRd_valid !== 1'b0) begin n_err++; $display("FAIL ae_rd60_valid got=%b exp=0", oRd_valid); end
        n_vec++; if (flat_rd() !== hold) begin n_err++; $display("FAIL ae_rd60_hold got=%h exp=%h", flat_rd(), hold); end
        rd(49, 0, 1'b0);
        n_vec++; if (oRd_valid !== 1'b0) begin n_err++; $display("FAIL ae_rd49_valid got=%b exp=0", oRd_valid); end
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ae_pending got=%0d exp=0", exp_q.size()); end
        pulse_release();
    endtask

    task automatic test_release_done_same();
        int o0;
        do_reset();
        o0 = ovf_cnt;
        fill_n(16'h5000, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL rd_same_a_rdy got=%b exp=1", oFrame_rdy); end
        fill_n(16'h6000, DEPTH, 1'b0);
        iFrame_done = 1'b1;
        iFrame_release = 1'b1;
        tick();
        iFrame_done = 1'b0;
        iFrame_release = 1'b0;
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL rd_same_drop_rdy got=%b exp=0", oFrame_rdy); end
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL rd_same_b_rdy got=%b exp=1", oFrame_rdy); end
        n_vec++; if (ovf_cnt != o0) begin n_err++; $display("FAIL rd_same_ovf got=%0d exp=0", ovf_cnt - o0); end
        rd(0, 16'h6000, 1'b1);
        rd(10, 16'h6000, 1'b1);
        rd(48, 16'h6000, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rd_same_pending got=%0d exp=0", exp_q.size()); end
        pulse_release();
    endtask

    task automatic test_reset_midframe();
        int o0;
        int a0;
        do_reset();
        fill_n(16'h7000, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL rm_a_rdy got=%b exp=1", oFrame_rdy); end
        fill_n(16'h7400, 20, 1'b0);
        iDmem_wren = 1'b1;
        iDmem_addr = AW'(20);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        iDmem_wren = 1'b0;
        exp_q.delete();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL rm_abandon got=%b exp=0", oFrame_rdy); end
        o0 = ovf_cnt;
        a0 = aerr_cnt;
        tick();
        tick();
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL rm_idle_rdy got=%b exp=0", oFrame_rdy); end
        fill_n(16'h7800, DEPTH, 1'b0);
        n_vec++; if (oFrame_rdy !== 1'b0) begin n_err++; $display("FAIL rm_prefill_rdy got=%b exp=0", oFrame_rdy); end
        pulse_done();
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL rm_new_rdy got=%b exp=1", oFrame_rdy); end
        for (int unsigned a = 0; a < DEPTH; a++) rd(a, 16'h7800, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rm_pending got=%0d exp=0", exp_q.size()); end
        n_vec++; if (ovf_cnt != o0) begin n_err++; $display("FAIL rm_ovf got=%0d exp=0", ovf_cnt - o0); end
        n_vec++; if (aerr_cnt != a0) begin n_err++; $display("FAIL rm_aerr got=%0d exp=0", aerr_cnt - a0); end
        pulse_release();
    endtask

    task automatic test_empty_frame();
        int o0;
        do_reset();
        o0 = ovf_cnt;
        pulse_done();
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ef_rdy got=%b exp=1", oFrame_rdy); end
        pulse_release();
        fill_n(16'h9000, DEPTH, 1'b1);
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL ef_next_rdy got=%b exp=1", oFrame_rdy); end
        rd(0, 16'h9000, 1'b1);
        rd(48, 16'h9000, 1'b1);
        tick();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ef_pending got=%0d exp=0", exp_q.size()); end
        n_vec++; if (ovf_cnt != o0) begin n_err++; $display("FAIL ef_ovf got=%0d exp=0", ovf_cnt - o0); end
        pulse_release();
    endtask

`ifdef IMG_BUF_CHKSUM_EN
    task automatic test_chksum();
        do_reset();
        for (int unsigned a = 0; a < DEPTH; a++) begin
            iDmem_wren = 1'b1;
            iDmem_addr = AW'(a);
            for (int unsigned l = 0; l < LANES; l++) iDmem_data[l] = 16'h0001;
            iFrame_done = (a == DEPTH - 1);
            tick();
        end
        iDmem_wren = 1'b0;
        iFrame_done = 1'b0;
        tick();
        n_vec++; if (oFrame_rdy !== 1'b1) begin n_err++; $display("FAIL cs_rdy got=%b exp=1", oFrame_rdy); end
        n_vec++; if (oChksum !== 16'h0310) begin n_err++; $display("FAIL cs_ones got=%h exp=0310", oChksum); end
        pulse_release();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_fill_read();
        test_overflow();
        test_addr_err();
        test_release_done_same();
        test_reset_midframe();
        test_empty_frame();
`ifdef IMG_BUF_CHKSUM_EN
        test_chksum();
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
